// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch modes behind a valid/ready
// interface with a two-entry (main + skid) buffer and synchronous flush.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic [TAG_W-1:0] tag_out
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext;

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic in_fire;
  logic out_fire;

  always_comb begin
    sign_ext = {{(OUT_W - IN_W){din[IN_W-1]}}, din};
    ext      = sign_ext;
    unique case (mode)
      2'd0: ext = sign_ext;
      2'd1: ext = {{(OUT_W - IN_W){1'b0}}, din};
      2'd2: ext = {din, {(OUT_W - IN_W){1'b0}}};
      2'd3: ext = {sign_ext[OUT_W-3:0], 2'b00};
      default: ext = sign_ext;
    endcase
  end

  // Ready depends only on stored state, so there is no out_ready -> in_ready path.
  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign dout      = main_data_q;
  assign tag_out   = main_tag_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = ext;
        main_tag_d   = tag_in;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = ext;
        main_tag_d   = tag_in;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ext;
        skid_tag_d   = tag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the datapath's decode/execute boundary.
- Takes an IN_W-bit immediate plus a 2-bit mode, produces an OUT_W-bit extended value one cycle later.
- Supports four extension modes: sign, zero, upper-load, and sign-shift-by-2 branch offset.
- Decoupled on both sides by a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or reorders data. Includes a synchronous flush for pipeline squash.

Parameters:
- IN_W, 16, immediate input width. Must be >= 2.
- OUT_W, 32, extended output width. Must be >= IN_W+2.
- TAG_W, 5, width of the sideband tag (e.g. destination register number) carried alongside the data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream has an immediate.
- in_ready  output  1  block can accept an input this cycle.
- din  input  IN_W  raw immediate.
- mode  input  2  extension mode: 0 sign, 1 zero, 2 upper, 3 branch.
- tag_in  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  dout/tag_out hold a valid result.
- out_ready  input  1  downstream accepts the result.
- dout  output  OUT_W  extended result.
- tag_out  output  TAG_W  tag of the result.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n=0: out_valid=0, dout=0, tag_out=0, both buffer entries invalid.
  - in_ready=1 once rst_n deasserts.
  - No transfer is accepted while rst_n=0.
- Extension arithmetic, all modes truncated/filled to exactly OUT_W bits:
  - Mode 0: {(OUT_W-IN_W){din[IN_W-1]}, din}.
  - Mode 1: {(OUT_W-IN_W){1'b0}, din}.
  - Mode 2: din placed in bits [OUT_W-1 : OUT_W-IN_W], all lower bits 0.
  - Mode 3: mode-0 result shifted left by 2; upper 2 bits discarded, bits [1:0]=0.
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- Storage is two entries: main (drives dout/tag_out/out_valid) and skid.
  - Extension is computed on the input side; both entries store the already-extended value.
- Latency: 1 cycle. A value accepted at edge N is presented at dout after edge N if main was empty or drained at edge N.
- in_ready = !skid_valid. It is a registered-state function only, with no combinational path from out_ready.
- Per-edge actions:
  - Input only, main empty or draining → load main.
  - Input only, main held (out_valid && !out_ready) → load skid.
  - Output only, skid valid → skid moves to main, skid clears.
  - Output only, skid empty → main clears.
  - Input and output with skid empty → new value loads main.
  - Input and output with skid valid → not possible, since in_ready=0.
- Ordering: strict FIFO; results leave in acceptance order.
- Hold rule: while out_valid && !out_ready, dout and tag_out stay stable.
- Flush:
  - At an edge with flush=1, both entries become invalid.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as delivered.
  - Next cycle: out_valid=0, in_ready=1.
  - dout/tag_out are not required to clear on flush.
- Reset mid-operation: all buffered entries are lost immediately, with no output transfer completing.
- Implementation: one always block for state, combinational extension logic; no latches.

Test Plan:
- Reset and mode 0 pass-through: reset, then send din=16'h8001, mode 0, tag 3, with out_ready=1 → next cycle out_valid=1, dout=32'hFFFF8001, tag_out=3. Before the input, out_valid=0 and dout=0.
- Mode sweep: din=16'h8001 in modes 1, 2, 3 → dout=32'h00008001, 32'h80010000, 32'hFFFE0004 respectively. din=16'h7FFF in mode 3 → 32'h0001FFFC.
- Back-pressure: out_ready=0, stream A=16'h0001, B=16'h0002, C=16'h0003 on consecutive cycles.
  - A sits in main, B in skid; in_ready drops to 0 and C is held upstream.
  - Raise out_ready → outputs A, B, C in order, one per cycle, with no loss.
- Full throughput: out_ready=1 with a continuous stream of 8 values → in_ready stays 1, out_valid=1 every cycle after the first, and each output equals its input extended one cycle later.
- Flush: with two entries buffered and an input presented, pulse flush for 1 cycle → next cycle out_valid=0, in_ready=1. Flushed values never appear on the output; the next input produces a correct result with 1-cycle latency.
- Async reset mid-stream: assert rst_n=0 between clock edges with both entries full → out_valid=0 and dout=0 immediately, without waiting for a clock edge. After release, in_ready=1.
